// File: rtl/d_cache_writeback_buffer_if.sv
// Bus bundle between the d_cache write port, the write-back buffer and the memory write master.
// The slave modport is the buffer's view; the master modport is the cache/memory side.
interface d_cache_writeback_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  c_control_go;
    logic [ADDR_WIDTH-1:0] c_control_base;
    logic [ADDR_WIDTH-1:0] c_control_length;
    logic                  c_control_done;
    logic                  c_user_we;
    logic [DATA_WIDTH-1:0] c_user_data;
    logic                  c_user_full;
    logic                  m_control_go;
    logic [ADDR_WIDTH-1:0] m_control_base;
    logic [ADDR_WIDTH-1:0] m_control_length;
    logic                  m_control_done;
    logic                  m_user_we;
    logic [DATA_WIDTH-1:0] m_user_data;
    logic                  m_user_full;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic                  rd_conflict;

    modport slave (
        input  c_control_go, c_control_base, c_control_length, c_user_we, c_user_data,
               m_control_done, m_user_full, rd_base,
        output c_control_done, c_user_full, m_control_go, m_control_base, m_control_length,
               m_user_we, m_user_data, rd_conflict
    );

    modport master (
        output c_control_go, c_control_base, c_control_length, c_user_we, c_user_data,
               m_control_done, m_user_full, rd_base,
        input  c_control_done, c_user_full, m_control_go, m_control_base, m_control_length,
               m_user_we, m_user_data, rd_conflict
    );
endinterface

// File: rtl/d_cache_writeback_buffer.sv
// Line-granular write-back buffer: absorbs flushed dirty lines from the d_cache at one word per
// cycle, drains them to memory in FIFO order, and flags refills that hit a pending line.
//
// state  | meaning
// IDLE   | waiting for a buffered line and an idle memory master
// ISSUE  | m_control_go pulse with the head line's base
// STREAM | pushing head line words while memory is not full
// WAIT   | waiting for memory done, then retiring the head slot
module d_cache_writeback_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    d_cache_writeback_buffer_if.slave bus
);
    localparam int WW  = $clog2(LINE_WORDS);
    localparam int OFF = WW + 2;
    localparam int PW  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW  = $clog2(LINES) + 1;
    localparam logic [CW-1:0]         LINES_C    = CW'(LINES);
    localparam logic [WW-1:0]         LAST_W     = WW'(LINE_WORDS - 1);
    localparam logic [PW-1:0]         LAST_P     = PW'(LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(LINE_WORDS * 4);

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, WAIT} drain_e;

    logic [ADDR_WIDTH-1:0] base_q [LINES];
    logic [ADDR_WIDTH-1:0] base_d [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES][LINE_WORDS];
    logic [LINES-1:0]      valid_q, valid_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  fill_q, fill_d;
    logic [WW-1:0]         fill_idx_q, fill_idx_d;

    drain_e                state_q;
    logic [WW-1:0]         rd_idx_q;
    logic                  m_go_q;
    logic [ADDR_WIDTH-1:0] m_base_q;

    logic c_done, go_ok, fill_word, fill_last, retire, conflict;
    logic unused_in;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    assign c_done    = ~fill_q & (count_q < LINES_C);
    assign go_ok     = bus.c_control_go & c_done;
    assign fill_word = fill_q & bus.c_user_we;
    assign fill_last = fill_word & (fill_idx_q == LAST_W);
    assign retire    = (state_q == WAIT) & bus.m_control_done;

    always_comb begin
        base_d     = base_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        fill_idx_d = fill_idx_q;
        if (go_ok) begin
            base_d[tail_q] = bus.c_control_base;
            fill_d         = 1'b1;
            fill_idx_d     = '0;
        end
        if (fill_word) fill_idx_d = fill_idx_q + 1'b1;
        if (fill_last) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = ptr_inc(tail_q);
            fill_d          = 1'b0;
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        // a completing fill and a retire in the same cycle cancel out
        count_d = count_q + CW'(fill_last) - CW'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) base_q[i] <= '0;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fill_q     <= 1'b0;
            fill_idx_q <= '0;
        end else begin
            base_q     <= base_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fill_q     <= fill_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_word) data_q[tail_q][fill_idx_q] <= bus.c_user_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_idx_q <= '0;
            m_go_q   <= 1'b0;
            m_base_q <= '0;
        end else begin
            m_go_q <= 1'b0;
            case (state_q)
                IDLE: if (count_q != '0 && bus.m_control_done) begin
                    state_q  <= ISSUE;
                    m_go_q   <= 1'b1;
                    m_base_q <= base_q[head_q];
                end
                ISSUE: begin
                    state_q  <= STREAM;
                    rd_idx_q <= '0;
                end
                STREAM: if (!bus.m_user_full) begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_W) state_q <= WAIT;
                end
                WAIT: if (bus.m_control_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // the slot being filled counts as pending so a refill cannot overtake it
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if ((valid_q[i] || (fill_q && tail_q == PW'(i))) &&
                base_q[i][ADDR_WIDTH-1:OFF] == bus.rd_base[ADDR_WIDTH-1:OFF])
                conflict = 1'b1;
        end
    end

    assign bus.c_control_done   = c_done;
    assign bus.c_user_full      = ~fill_q;
    assign bus.m_control_go     = m_go_q;
    assign bus.m_control_base   = m_base_q;
    assign bus.m_control_length = LINE_BYTES;
    assign bus.m_user_we        = (state_q == STREAM) & ~bus.m_user_full;
    assign bus.m_user_data      = data_q[head_q][rd_idx_q];
    assign bus.rd_conflict      = conflict;

    assign unused_in = ^{bus.c_control_length, bus.rd_base[OFF-1:0]};
endmodule

// File: tb/tb_d_cache_writeback_buffer.sv
// Self-checking bench: random line contents are pushed through the buffer and the drained
// stream is compared against an in-order line queue kept by the bench.
module tb_d_cache_writeback_buffer;
    typedef logic [3:0][31:0] words_t;

    logic clk;
    logic rst_n;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   full_viol = 0;
    int   full_mode = 0;
    bit   done_mode = 1'b0;
    logic [31:0] obs_bases[$];
    logic [31:0] obs_words[$];
    logic [31:0] exp_bases[$];
    logic [31:0] exp_words[$];

    d_cache_writeback_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    d_cache_writeback_buffer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .LINES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory-side behaviour: backpressure pattern and optional random done
    initial forever begin
        @(posedge clk); #1;
        case (full_mode)
            0:       bus.m_user_full = 1'b0;
            1:       bus.m_user_full = ~bus.m_user_full;
            default: bus.m_user_full = 1'($urandom_range(0, 1));
        endcase
        if (done_mode) bus.m_control_done = 1'($urandom_range(0, 1));
    end

    // record what reaches memory
    initial forever begin
        @(negedge clk);
        if (bus.m_control_go === 1'b1) obs_bases.push_back(bus.m_control_base);
        if (bus.m_user_we === 1'b1) begin
            obs_words.push_back(bus.m_user_data);
            if (bus.m_user_full !== 1'b0) full_viol++;
        end
    end

    task automatic clear_all();
        obs_bases.delete(); obs_words.delete();
        exp_bases.delete(); exp_words.delete();
        full_viol = 0;
    endtask

    task automatic add_line(input logic [31:0] base, input words_t w);
        exp_bases.push_back(base);
        for (int i = 0; i < 4; i++) exp_words.push_back(w[i]);
    endtask

    function automatic words_t rand_words();
        words_t w;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        return w;
    endfunction

    task automatic flush_line(input logic [31:0] base, input words_t w, input bit gaps,
                              output bit ok, output logic done_mid, output logic full_mid);
        int n;
        ok = 1'b0; done_mid = 1'bx; full_mid = 1'bx; n = 0;
        @(posedge clk); #1;
        while (bus.c_control_done !== 1'b1) begin
            if (n == 500) return;
            n++;
            @(posedge clk); #1;
        end
        bus.c_control_go = 1'b1; bus.c_control_base = base;
        @(posedge clk); #1;
        bus.c_control_go = 1'b0;
        done_mid = bus.c_control_done; full_mid = bus.c_user_full;
        for (int i = 0; i < 4; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.c_user_we = 1'b0;
                @(posedge clk); #1;
            end
            bus.c_user_we = 1'b1; bus.c_user_data = w[i];
            @(posedge clk); #1;
        end
        bus.c_user_we = 1'b0;
        add_line(base, w);
        ok = 1'b1;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk); #1;
            if (obs_words.size() >= n) ok = 1'b1;
        end
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.c_control_done !== 1'b1) $display("FAIL rst_c_done got %b want 1", bus.c_control_done); else n_pass++;
        n_checks++; if (bus.c_user_full !== 1'b1) $display("FAIL rst_c_full got %b want 1", bus.c_user_full); else n_pass++;
        n_checks++; if (bus.m_control_go !== 1'b0) $display("FAIL rst_m_go got %b want 0", bus.m_control_go); else n_pass++;
        n_checks++; if (bus.m_user_we !== 1'b0) $display("FAIL rst_m_we got %b want 0", bus.m_user_we); else n_pass++;
        n_checks++; if (bus.m_control_base !== 32'h0) $display("FAIL rst_m_base got %h want 0", bus.m_control_base); else n_pass++;
        n_checks++; if (bus.rd_conflict !== 1'b0) $display("FAIL rst_conflict got %b want 0", bus.rd_conflict); else n_pass++;
        n_checks++; if (bus.m_control_length !== 32'd16) $display("FAIL rst_m_len got %0d want 16", bus.m_control_length); else n_pass++;
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.c_control_done !== 1'b1) $display("FAIL rst_post_done got %b want 1", bus.c_control_done); else n_pass++;
    endtask

    task automatic test_single_flush();
        words_t w; bit ok; logic dm, fm;
        clear_all();
        w = rand_words();
        flush_line(32'h100, w, 1'b0, ok, dm, fm);
        n_checks++; if (!ok) $display("FAIL t1_accept got timeout want accepted"); else n_pass++;
        n_checks++; if (dm !== 1'b0) $display("FAIL t1_done_mid got %b want 0", dm); else n_pass++;
        n_checks++; if (fm !== 1'b0) $display("FAIL t1_full_mid got %b want 0", fm); else n_pass++;
        wait_words(4, 100, ok);
        n_checks++; if (!ok) $display("FAIL t1_drain got %0d words want 4", obs_words.size()); else n_pass++;
        n_checks++; if (obs_bases.size() != 1) $display("FAIL t1_ngo got %0d want 1", obs_bases.size()); else n_pass++;
        if (obs_bases.size() > 0) begin
            n_checks++; if (obs_bases[0] !== 32'h100) $display("FAIL t1_base got %h want 100", obs_bases[0]); else n_pass++;
        end
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
            n_checks++; if (obs_words[i] !== exp_words[i]) $display("FAIL t1_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else n_pass++;
        end
        n_checks++; if (bus.c_control_done !== 1'b1) $display("FAIL t1_done_end got %b want 1", bus.c_control_done); else n_pass++;
    endtask

    task automatic test_hold_done();
        words_t w; bit ok; logic dm, fm;
        clear_all();
        bus.m_control_done = 1'b0;
        for (int l = 0; l < 2; l++) begin
            w = rand_words();
            flush_line(32'h300 + 32'(l) * 32'h100, w, 1'b1, ok, dm, fm);
            n_checks++; if (!ok) $display("FAIL t2_accept%0d got timeout want accepted", l); else n_pass++;
        end
        n_checks++; if (bus.c_control_done !== 1'b0) $display("FAIL t2_done_full got %b want 0", bus.c_control_done); else n_pass++;
        bus.c_control_go = 1'b1; bus.c_control_base = 32'h0000_0A00;
        @(posedge clk); #1;
        bus.c_control_go = 1'b0;
        n_checks++; if (bus.c_user_full !== 1'b1) $display("FAIL t2_ignored_go got full=%b want 1", bus.c_user_full); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus.c_user_we = 1'b1; bus.c_user_data = $urandom;
            @(posedge clk); #1;
        end
        bus.c_user_we = 1'b0;
        n_checks++; if (obs_bases.size() != 0) $display("FAIL t2_held got %0d go want 0", obs_bases.size()); else n_pass++;
        bus.m_control_done = 1'b1;
        wait_words(8, 200, ok);
        n_checks++; if (!ok) $display("FAIL t2_drain got %0d words want 8", obs_words.size()); else n_pass++;
        n_checks++; if (obs_bases.size() != 2) $display("FAIL t2_ngo got %0d want 2", obs_bases.size()); else n_pass++;
        for (int i = 0; i < exp_bases.size() && i < obs_bases.size(); i++) begin
            n_checks++; if (obs_bases[i] !== exp_bases[i]) $display("FAIL t2_base%0d got %h want %h", i, obs_bases[i], exp_bases[i]); else n_pass++;
        end
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
            n_checks++; if (obs_words[i] !== exp_words[i]) $display("FAIL t2_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        words_t w; bit ok; logic dm, fm;
        clear_all();
        full_mode = 1;
        for (int l = 0; l < 2; l++) begin
            w = rand_words();
            flush_line({$urandom} & 32'hFFFF_FFF0, w, 1'b1, ok, dm, fm);
            n_checks++; if (!ok) $display("FAIL t3_accept%0d got timeout want accepted", l); else n_pass++;
        end
        wait_words(8, 300, ok);
        full_mode = 0;
        n_checks++; if (obs_words.size() != 8) $display("FAIL t3_nwords got %0d want 8", obs_words.size()); else n_pass++;
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
            n_checks++; if (obs_words[i] !== exp_words[i]) $display("FAIL t3_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else n_pass++;
        end
        n_checks++; if (full_viol != 0) $display("FAIL t3_we_while_full got %0d want 0", full_viol); else n_pass++;
    endtask

    task automatic test_conflict();
        words_t w; bit ok; logic dm, fm; int seen;
        clear_all();
        bus.m_control_done = 1'b0;
        bus.rd_base = 32'h208;
        w = rand_words();
        flush_line(32'h200, w, 1'b0, ok, dm, fm);
        n_checks++; if (bus.rd_conflict !== 1'b1) $display("FAIL t4_hit got %b want 1", bus.rd_conflict); else n_pass++;
        bus.rd_base = 32'h210; #1;
        n_checks++; if (bus.rd_conflict !== 1'b0) $display("FAIL t4_next_line got %b want 0", bus.rd_conflict); else n_pass++;
        bus.rd_base = 32'h1FC; #1;
        n_checks++; if (bus.rd_conflict !== 1'b0) $display("FAIL t4_prev_line got %b want 0", bus.rd_conflict); else n_pass++;
        bus.rd_base = 32'h20F; #1;
        n_checks++; if (bus.rd_conflict !== 1'b1) $display("FAIL t4_line_top got %b want 1", bus.rd_conflict); else n_pass++;
        bus.rd_base = 32'h208;
        bus.m_control_done = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && seen < 4; c++) begin
            @(negedge clk);
            if (bus.m_user_we === 1'b1) seen++;
        end
        n_checks++; if (seen != 4) $display("FAIL t4_drain got %0d words want 4", seen); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.rd_conflict !== 1'b1) $display("FAIL t4_before_retire got %b want 1", bus.rd_conflict); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.rd_conflict !== 1'b0) $display("FAIL t4_after_retire got %b want 0", bus.rd_conflict); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_retire_overlap();
        words_t wa, wb; bit ok, go_seen; logic dm, fm; int seen;
        logic [31:0] ba, bb;
        clear_all();
        ba = 32'h0000_4440; bb = 32'h0000_7770;
        wa = rand_words(); wb = rand_words();
        bus.m_control_done = 1'b1;
        flush_line(ba, wa, 1'b0, ok, dm, fm);
        n_checks++; if (!ok) $display("FAIL t5_accept_a got timeout want accepted"); else n_pass++;
        add_line(bb, wb);
        seen = 0; go_seen = 1'b0;
        fork
            begin
                n_checks++; if (bus.c_control_done !== 1'b1) $display("FAIL t5_done_b got %b want 1", bus.c_control_done); else n_pass++;
                bus.c_control_go = 1'b1; bus.c_control_base = bb;
                @(posedge clk); #1;
                bus.c_control_go = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    bus.c_user_we = 1'b1; bus.c_user_data = wb[i];
                    @(posedge clk); #1;
                end
                bus.c_user_we = 1'b0;
            end
            begin
                for (int c = 0; c < 50 && !go_seen; c++) begin
                    @(negedge clk);
                    if (bus.m_control_go === 1'b1) go_seen = 1'b1;
                end
                @(posedge clk); #1;
                bus.m_control_done = 1'b0;
                for (int c = 0; c < 50 && seen < 4; c++) begin
                    @(negedge clk);
                    if (bus.m_user_we === 1'b1) seen++;
                end
                @(posedge clk); #1;
                bus.c_user_we = 1'b1; bus.c_user_data = wb[3];
                bus.m_control_done = 1'b1;
                @(posedge clk); #1;
                bus.c_user_we = 1'b0;
            end
        join
        n_checks++; if (!go_seen || seen != 4) $display("FAIL t5_stream_a got go=%b words=%0d want go=1 words=4", go_seen, seen); else n_pass++;
        n_checks++; if (bus.c_control_done !== 1'b1) $display("FAIL t5_done_after got %b want 1", bus.c_control_done); else n_pass++;
        bus.rd_base = ba; #1;
        n_checks++; if (bus.rd_conflict !== 1'b0) $display("FAIL t5_a_retired got %b want 0", bus.rd_conflict); else n_pass++;
        bus.rd_base = bb; #1;
        n_checks++; if (bus.rd_conflict !== 1'b1) $display("FAIL t5_b_pending got %b want 1", bus.rd_conflict); else n_pass++;
        wait_words(8, 100, ok);
        n_checks++; if (obs_bases.size() != 2) $display("FAIL t5_ngo got %0d want 2", obs_bases.size()); else n_pass++;
        for (int i = 0; i < exp_bases.size() && i < obs_bases.size(); i++) begin
            n_checks++; if (obs_bases[i] !== exp_bases[i]) $display("FAIL t5_base%0d got %h want %h", i, obs_bases[i], exp_bases[i]); else n_pass++;
        end
        n_checks++; if (obs_words.size() != 8) $display("FAIL t5_nwords got %0d want 8", obs_words.size()); else n_pass++;
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
            n_checks++; if (obs_words[i] !== exp_words[i]) $display("FAIL t5_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_stream();
        words_t w; bit ok; logic dm, fm; int seen;
        clear_all();
        w = rand_words();
        bus.rd_base = 32'h0000_5550;
        flush_line(32'h0000_5550, w, 1'b0, ok, dm, fm);
        seen = 0;
        for (int c = 0; c < 50 && seen < 2; c++) begin
            @(negedge clk);
            if (bus.m_user_we === 1'b1) seen++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.m_user_we !== 1'b0) $display("FAIL t6_we got %b want 0", bus.m_user_we); else n_pass++;
        n_checks++; if (bus.m_control_go !== 1'b0) $display("FAIL t6_go got %b want 0", bus.m_control_go); else n_pass++;
        n_checks++; if (bus.m_control_base !== 32'h0) $display("FAIL t6_base got %h want 0", bus.m_control_base); else n_pass++;
        n_checks++; if (bus.c_control_done !== 1'b1) $display("FAIL t6_done got %b want 1", bus.c_control_done); else n_pass++;
        n_checks++; if (bus.c_user_full !== 1'b1) $display("FAIL t6_full got %b want 1", bus.c_user_full); else n_pass++;
        n_checks++; if (bus.rd_conflict !== 1'b0) $display("FAIL t6_conflict got %b want 0", bus.rd_conflict); else n_pass++;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (obs_words.size() != 2) $display("FAIL t6_no_more_words got %0d want 2", obs_words.size()); else n_pass++;
        clear_all();
        w = rand_words();
        flush_line(32'h0000_6660, w, 1'b0, ok, dm, fm);
        wait_words(4, 100, ok);
        n_checks++; if (obs_bases.size() != 1) $display("FAIL t6_fresh_ngo got %0d want 1", obs_bases.size()); else n_pass++;
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
            n_checks++; if (obs_words[i] !== exp_words[i]) $display("FAIL t6_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else n_pass++;
        end
    endtask

    task automatic test_random_traffic();
        words_t w; bit ok; logic dm, fm;
        clear_all();
        full_mode = 2;
        done_mode = 1'b1;
        for (int l = 0; l < 6; l++) begin
            w = rand_words();
            flush_line({$urandom} & 32'hFFFF_FFF0, w, 1'b1, ok, dm, fm);
            n_checks++; if (!ok) $display("FAIL t7_accept%0d got timeout want accepted", l); else n_pass++;
        end
        wait_words(24, 3000, ok);
        done_mode = 1'b0;
        full_mode = 0;
        bus.m_control_done = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (obs_bases.size() != exp_bases.size()) $display("FAIL t7_ngo got %0d want %0d", obs_bases.size(), exp_bases.size()); else n_pass++;
        for (int i = 0; i < exp_bases.size() && i < obs_bases.size(); i++) begin
            n_checks++; if (obs_bases[i] !== exp_bases[i]) $display("FAIL t7_base%0d got %h want %h", i, obs_bases[i], exp_bases[i]); else n_pass++;
        end
        n_checks++; if (obs_words.size() != exp_words.size()) $display("FAIL t7_nwords got %0d want %0d", obs_words.size(), exp_words.size()); else n_pass++;
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
            n_checks++; if (obs_words[i] !== exp_words[i]) $display("FAIL t7_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else n_pass++;
        end
        n_checks++; if (full_viol != 0) $display("FAIL t7_we_while_full got %0d want 0", full_viol); else n_pass++;
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.c_control_go     = 1'b0;
        bus.c_control_base   = '0;
        bus.c_control_length = 32'd16;
        bus.c_user_we        = 1'b0;
        bus.c_user_data      = '0;
        bus.m_control_done   = 1'b1;
        bus.m_user_full      = 1'b0;
        bus.rd_base          = '0;
        test_reset();
        test_single_flush();
        test_hold_done();
        test_backpressure();
        test_conflict();
        test_retire_overlap();
        test_reset_mid_stream();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
